// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: butterfly latency, a wide complex container,
// and the rounding / saturation helpers used by the butterfly stages.
package fft_pkg;

   localparam int BF_LATENCY = 4;
   localparam int WIDE_W     = 64;

   // Wide enough for any intermediate of the supported widths; callers cast down.
   typedef logic signed [WIDE_W-1:0] wide_t;

   typedef struct packed {
      wide_t re;
      wide_t im;
   } cplx_t;

   // Round-half-up arithmetic right shift.
   function automatic wide_t round_shift(wide_t v, int unsigned sh);
      wide_t half;
      if (sh == 0) return v;
      half = wide_t'(1) << (sh - 1);
      return (v + half) >>> sh;
   endfunction

   // Clamp to the signed range of an out_w-bit two's complement value.
   function automatic wide_t sat(wide_t v, int unsigned out_w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) << (out_w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) << (out_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/cmplx_mult_rnd.sv
// Two-register complex multiplier: full-precision partial products, then
// combine and round-half-up back to Q0 with one guard bit of growth.
module cmplx_mult_rnd
   import fft_pkg::*;
#(
   parameter int IN_W = 17,
   parameter int TW_W = 10
) (
   input  logic            clk,
   input  logic            en,
   input  logic [IN_W-1:0] x_re,
   input  logic [IN_W-1:0] x_im,
   input  logic [TW_W-1:0] w_re,
   input  logic [TW_W-1:0] w_im,
   output logic [IN_W:0]   y_re,
   output logic [IN_W:0]   y_im
);

   localparam int          PW = IN_W + TW_W;
   localparam int unsigned SH = TW_W - 2;

   logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
   logic signed [IN_W:0] re_rnd, im_rnd;

   // Register the four full-precision partial products.
   always_ff @(posedge clk) begin
      if (en) begin
         rr_q <= PW'($signed(x_re)) * PW'($signed(w_re));
         ii_q <= PW'($signed(x_im)) * PW'($signed(w_im));
         ri_q <= PW'($signed(x_re)) * PW'($signed(w_im));
         ir_q <= PW'($signed(x_im)) * PW'($signed(w_re));
      end
   end

   // Combine at full precision before rounding so only one rounding error occurs.
   always_comb begin
      re_rnd = (IN_W + 1)'(round_shift(wide_t'(rr_q) - wide_t'(ii_q), SH));
      im_rnd = (IN_W + 1)'(round_shift(wide_t'(ri_q) + wide_t'(ir_q), SH));
   end

   // Register the rounded product.
   always_ff @(posedge clk) begin
      if (en) begin
         y_re <= re_rnd;
         y_im <= im_rnd;
      end
   end

endmodule

// File: rtl/butterfly_r2_cfg.sv
// Radix-2 butterfly with run-time DIF/DIT selection, optional per-sample 1-bit
// scaling, round-half-up and output saturation. Fixed 4 enabled-cycle latency.
// OUT_WIDTH must lie in [WIDTH, WIDTH+2].
module butterfly_r2_cfg
   import fft_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int TW_WIDTH  = 10,
   parameter int OUT_WIDTH = WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 i_valid,
   input  logic                 i_mode_dit,
   input  logic                 i_scale,
   input  logic [WIDTH-1:0]     a_real,
   input  logic [WIDTH-1:0]     a_imag,
   input  logic [WIDTH-1:0]     b_real,
   input  logic [WIDTH-1:0]     b_imag,
   input  logic [TW_WIDTH-1:0]  twiddle_real,
   input  logic [TW_WIDTH-1:0]  twiddle_imag,
   input  logic                 clr_ovf,
   output logic [OUT_WIDTH-1:0] y1_real,
   output logic [OUT_WIDTH-1:0] y1_imag,
   output logic [OUT_WIDTH-1:0] y2_real,
   output logic [OUT_WIDTH-1:0] y2_imag,
   output logic                 o_valid,
   output logic                 o_sat,
   output logic                 o_ovf_sticky
);

   localparam int SW = WIDTH + 1;  // stage-1 sum/difference width
   localparam int MW = WIDTH + 2;  // multiplier result width

   logic                    v1_q, v2_q, v3_q;
   logic                    dit1_q, dit2_q, dit3_q;
   logic                    sc1_q, sc2_q, sc3_q;
   logic signed [WIDTH-1:0] a1_re_q, a1_im_q;
   logic signed [SW-1:0]    sum1_re_q, sum1_im_q;
   logic signed [SW-1:0]    mx1_re_q, mx1_im_q;
   logic [TW_WIDTH-1:0]     w1_re_q, w1_im_q;
   logic signed [SW-1:0]    p2_re_q, p2_im_q, p3_re_q, p3_im_q;
   logic [MW-1:0]           t_re, t_im;
   cplx_t                   u1, u2;
   logic [OUT_WIDTH-1:0]    y1_re_d, y1_im_d, y2_re_d, y2_im_d;
   logic                    sat_d, sticky_d;

   // Valid pipeline: the only pipeline state cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
      end else if (clk_en) begin
         v1_q <= i_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
      end
   end

   // Data pipeline S1..S3; mode and scale travel alongside each sample.
   // The multiplier operand is A-B for DIF and B for DIT; the pass-through operand
   // is A+B for DIF and A for DIT.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         dit1_q    <= i_mode_dit;
         sc1_q     <= i_scale;
         a1_re_q   <= $signed(a_real);
         a1_im_q   <= $signed(a_imag);
         sum1_re_q <= SW'($signed(a_real)) + SW'($signed(b_real));
         sum1_im_q <= SW'($signed(a_imag)) + SW'($signed(b_imag));
         mx1_re_q  <= i_mode_dit ? SW'($signed(b_real))
                                 : SW'($signed(a_real)) - SW'($signed(b_real));
         mx1_im_q  <= i_mode_dit ? SW'($signed(b_imag))
                                 : SW'($signed(a_imag)) - SW'($signed(b_imag));
         w1_re_q   <= twiddle_real;
         w1_im_q   <= twiddle_imag;
         dit2_q    <= dit1_q;
         sc2_q     <= sc1_q;
         p2_re_q   <= dit1_q ? SW'(a1_re_q) : sum1_re_q;
         p2_im_q   <= dit1_q ? SW'(a1_im_q) : sum1_im_q;
         dit3_q    <= dit2_q;
         sc3_q     <= sc2_q;
         p3_re_q   <= p2_re_q;
         p3_im_q   <= p2_im_q;
      end
   end

   cmplx_mult_rnd #(
      .IN_W (SW),
      .TW_W (TW_WIDTH)
   ) u_mult (
      .clk  (clk),
      .en   (clk_en),
      .x_re (mx1_re_q),
      .x_im (mx1_im_q),
      .w_re (w1_re_q),
      .w_im (w1_im_q),
      .y_re (t_re),
      .y_im (t_im)
   );

   // Final combine, optional scale and saturation. The DIT add/sub is formed wide
   // so A +/- T cannot wrap before the clamp.
   always_comb begin
      u1 = '0;
      u2 = '0;
      if (dit3_q) begin
         u1.re = wide_t'(p3_re_q) + wide_t'($signed(t_re));
         u1.im = wide_t'(p3_im_q) + wide_t'($signed(t_im));
         u2.re = wide_t'(p3_re_q) - wide_t'($signed(t_re));
         u2.im = wide_t'(p3_im_q) - wide_t'($signed(t_im));
      end else begin
         u1.re = wide_t'(p3_re_q);
         u1.im = wide_t'(p3_im_q);
         u2.re = wide_t'($signed(t_re));
         u2.im = wide_t'($signed(t_im));
      end
      if (sc3_q) begin
         u1.re = round_shift(u1.re, 1);
         u1.im = round_shift(u1.im, 1);
         u2.re = round_shift(u2.re, 1);
         u2.im = round_shift(u2.im, 1);
      end
      y1_re_d = OUT_WIDTH'(sat(u1.re, OUT_WIDTH));
      y1_im_d = OUT_WIDTH'(sat(u1.im, OUT_WIDTH));
      y2_re_d = OUT_WIDTH'(sat(u2.re, OUT_WIDTH));
      y2_im_d = OUT_WIDTH'(sat(u2.im, OUT_WIDTH));
      sat_d   = (sat(u1.re, OUT_WIDTH) != u1.re) | (sat(u1.im, OUT_WIDTH) != u1.im) |
                (sat(u2.re, OUT_WIDTH) != u2.re) | (sat(u2.im, OUT_WIDTH) != u2.im);
      // The set event is the saturated sample being loaded, so the flag rises
      // together with o_sat; a simultaneous clear loses.
      sticky_d = (clk_en & v3_q & sat_d) | (o_ovf_sticky & ~clr_ovf);
   end

   // S4 output registers; data and o_sat only reload when a valid sample arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         y1_real      <= '0;
         y1_imag      <= '0;
         y2_real      <= '0;
         y2_imag      <= '0;
         o_valid      <= 1'b0;
         o_sat        <= 1'b0;
         o_ovf_sticky <= 1'b0;
      end else begin
         if (clk_en) begin
            o_valid <= v3_q;
            if (v3_q) begin
               y1_real <= y1_re_d;
               y1_imag <= y1_im_d;
               y2_real <= y2_re_d;
               y2_imag <= y2_im_d;
               o_sat   <= sat_d;
            end
         end
         o_ovf_sticky <= sticky_d;
      end
   end

endmodule

// File: tb/tb_butterfly_r2_cfg.sv
// Bench for butterfly_r2_cfg: two instances (OUT_WIDTH 17 and 16) share stimulus
// and are compared every cycle against a queue-based arithmetic model, plus
// literal checks on the hand-worked vectors.
module tb_butterfly_r2_cfg;
   import fft_pkg::*;

   localparam int TW = 10;

   logic clk = 1'b0;
   logic rst, clk_en, i_valid, i_mode_dit, i_scale, clr_ovf;
   logic [15:0] a_real, a_imag, b_real, b_imag;
   logic [TW-1:0] twiddle_real, twiddle_imag;

   logic [16:0] y1r17, y1i17, y2r17, y2i17;
   logic        v17, s17, st17;
   logic [15:0] y1r16, y1i16, y2r16, y2i16;
   logic        v16, s16, st16;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   butterfly_r2_cfg #(.WIDTH(16), .TW_WIDTH(TW), .OUT_WIDTH(17)) dut17 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .i_mode_dit(i_mode_dit),
      .i_scale(i_scale), .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
      .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag), .clr_ovf(clr_ovf),
      .y1_real(y1r17), .y1_imag(y1i17), .y2_real(y2r17), .y2_imag(y2i17),
      .o_valid(v17), .o_sat(s17), .o_ovf_sticky(st17));

   butterfly_r2_cfg #(.WIDTH(16), .TW_WIDTH(TW), .OUT_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .i_mode_dit(i_mode_dit),
      .i_scale(i_scale), .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
      .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag), .clr_ovf(clr_ovf),
      .y1_real(y1r16), .y1_imag(y1i16), .y2_real(y2r16), .y2_imag(y2i16),
      .o_valid(v16), .o_sat(s16), .o_ovf_sticky(st16));

   typedef struct {
      longint y1r, y1i, y2r, y2i;
      bit     sat;
   } res_t;

   typedef struct {
      int   due;
      res_t r17;
      res_t r16;
   } ent_t;

   ent_t q[$];
   int   ecnt = 0;
   bit   e_valid = 1'b0;
   res_t e17, e16;
   bit   est17 = 1'b0, est16 = 1'b0;

   function automatic longint rnd(longint v);
      return (v + (longint'(1) << (TW - 3))) >>> (TW - 2);
   endfunction

   function automatic longint clip(longint v, int ow);
      longint hi, lo;
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -(longint'(1) << (ow - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Butterfly straight from the arithmetic definition, in plain integers.
   function automatic res_t model(input int ar, input int ai, input int br, input int bi,
                                  input int wr, input int wi, input bit dit, input bit sc,
                                  input int ow);
      longint u[4];
      longint tr, ti, c;
      res_t   r;
      if (dit) begin
         tr = rnd(longint'(br) * wr - longint'(bi) * wi);
         ti = rnd(longint'(br) * wi + longint'(bi) * wr);
         u[0] = ar + tr;
         u[1] = ai + ti;
         u[2] = ar - tr;
         u[3] = ai - ti;
      end else begin
         u[0] = ar + br;
         u[1] = ai + bi;
         u[2] = rnd(longint'(ar - br) * wr - longint'(ai - bi) * wi);
         u[3] = rnd(longint'(ar - br) * wi + longint'(ai - bi) * wr);
      end
      r.sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (sc) u[i] = (u[i] + 1) >>> 1;
         c = clip(u[i], ow);
         if (c != u[i]) r.sat = 1'b1;
         u[i] = c;
      end
      r.y1r = u[0];
      r.y1i = u[1];
      r.y2r = u[2];
      r.y2i = u[3];
      return r;
   endfunction

   function automatic int sx16(input logic [15:0] x);
      return int'($signed(x));
   endfunction

   function automatic int sxtw(input logic [TW-1:0] x);
      return int'($signed(x));
   endfunction

   // Model update on every clock edge: latency counted in enabled edges.
   always @(posedge clk) begin
      ent_t e;
      bit   nv;
      nv = 1'b0;
      if (rst) begin
         q.delete();
         e_valid = 1'b0;
         e17 = '{default: 0};
         e16 = '{default: 0};
         est17 = 1'b0;
         est16 = 1'b0;
      end else begin
         if (clk_en) begin
            ecnt++;
            if (q.size() > 0 && q[0].due == ecnt) begin
               e = q.pop_front();
               nv = 1'b1;
               e17 = e.r17;
               e16 = e.r16;
            end
            e_valid = nv;
            if (i_valid) begin
               e.due = ecnt + BF_LATENCY - 1;
               e.r17 = model(sx16(a_real), sx16(a_imag), sx16(b_real), sx16(b_imag),
                             sxtw(twiddle_real), sxtw(twiddle_imag), i_mode_dit, i_scale, 17);
               e.r16 = model(sx16(a_real), sx16(a_imag), sx16(b_real), sx16(b_imag),
                             sxtw(twiddle_real), sxtw(twiddle_imag), i_mode_dit, i_scale, 16);
               q.push_back(e);
            end
         end
         est17 = (nv && e17.sat) ? 1'b1 : (clr_ovf ? 1'b0 : est17);
         est16 = (nv && e16.sat) ? 1'b1 : (clr_ovf ? 1'b0 : est16);
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("valid17", longint'(v17), longint'(e_valid));
         check("y1r17", longint'($signed(y1r17)), e17.y1r);
         check("y1i17", longint'($signed(y1i17)), e17.y1i);
         check("y2r17", longint'($signed(y2r17)), e17.y2r);
         check("y2i17", longint'($signed(y2i17)), e17.y2i);
         check("sat17", longint'(s17), longint'(e17.sat));
         check("sticky17", longint'(st17), longint'(est17));
         check("valid16", longint'(v16), longint'(e_valid));
         check("y1r16", longint'($signed(y1r16)), e16.y1r);
         check("y1i16", longint'($signed(y1i16)), e16.y1i);
         check("y2r16", longint'($signed(y2r16)), e16.y2r);
         check("y2i16", longint'($signed(y2i16)), e16.y2i);
         check("sat16", longint'(s16), longint'(e16.sat));
         check("sticky16", longint'(st16), longint'(est16));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi, input bit dit, input bit sc);
      a_real = 16'(ar);
      a_imag = 16'(ai);
      b_real = 16'(br);
      b_imag = 16'(bi);
      twiddle_real = TW'(wr);
      twiddle_imag = TW'(wi);
      i_mode_dit = dit;
      i_scale = sc;
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) step();
   endtask

   int nsent;

   initial begin
      rst = 1'b1; clk_en = 1'b1; i_valid = 1'b0; i_mode_dit = 1'b0; i_scale = 1'b0;
      clr_ovf = 1'b0; a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
      twiddle_real = '0; twiddle_imag = '0;
      step();
      chk_on = 1'b1;
      step();
      rst = 1'b0;
      check("rst_valid", longint'(v17), 0);
      check("rst_y1r", longint'($signed(y1r17)), 0);
      check("rst_sticky", longint'(st16), 0);

      // DIF, unit twiddle
      send(1000, 200, 600, -100, 256, 0, 1'b0, 1'b0);
      idle(3);
      check("dif_valid", longint'(v17), 1);
      check("dif_y1r", longint'($signed(y1r17)), 1600);
      check("dif_y1i", longint'($signed(y1i17)), 100);
      check("dif_y2r", longint'($signed(y2r17)), 400);
      check("dif_y2i", longint'($signed(y2i17)), 300);
      check("dif_sat", longint'(s17), 0);

      // DIT, twiddle -j
      send(1000, 200, 600, -100, 0, -256, 1'b1, 1'b0);
      idle(3);
      check("dit_y1r", longint'($signed(y1r17)), 900);
      check("dit_y1i", longint'($signed(y1i17)), -400);
      check("dit_y2r", longint'($signed(y2r17)), 1100);
      check("dit_y2i", longint'($signed(y2i17)), 800);

      // Alternating modes back to back
      for (int i = 0; i < 8; i++)
         send(100 * i - 300, 50 * i, -70 * i, 20 - 9 * i, (i % 3 == 0) ? 181 : 0, -181,
              i[0], 1'b0);
      idle(4);

      // Rounding of the product and of the scale step
      send(3, -3, 0, 0, 128, 0, 1'b0, 1'b0);
      idle(3);
      check("rnd_y2r", longint'($signed(y2r17)), 2);
      check("rnd_y2i", longint'($signed(y2i17)), -1);
      send(3, -3, 0, 0, 256, 0, 1'b0, 1'b1);
      idle(3);
      check("scl_y1r", longint'($signed(y1r17)), 2);
      check("scl_y1i", longint'($signed(y1i17)), -1);

      // Saturation on the 16-bit-output instance
      send(32767, -32768, 32767, -32768, 256, 0, 1'b0, 1'b0);
      idle(3);
      check("sat_y1r", longint'($signed(y1r16)), 32767);
      check("sat_y1i", longint'($signed(y1i16)), -32768);
      check("sat_flag16", longint'(s16), 1);
      check("sat_sticky16", longint'(st16), 1);
      check("sat_flag17", longint'(s17), 0);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("clr_sticky16", longint'(st16), 0);
      send(32767, -32768, 32767, -32768, 256, 0, 1'b0, 1'b0);
      idle(2);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("setwins_sticky16", longint'(st16), 1);
      idle(2);

      // Stall mid-stream
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            clk_en = 1'b0;
            i_valid = 1'b1;
            repeat (3) step();
            clk_en = 1'b1;
         end
         send(1234 - 321 * i, 77 * i, 500, -250 + i, 256, -128, i[1], i[0]);
      end
      idle(5);

      // Reset mid-stream
      send(111, 222, 333, 444, 256, 0, 1'b0, 1'b0);
      send(-111, -222, 333, 444, 0, 256, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid", longint'(v17), 0);
      idle(6);

      // Random scoreboard run
      nsent = 0;
      while (nsent < 10000) begin
         clk_en = ($urandom_range(0, 9) != 0);
         i_valid = ($urandom_range(0, 9) != 0);
         i_mode_dit = $urandom_range(0, 1) == 1;
         i_scale = $urandom_range(0, 1) == 1;
         clr_ovf = ($urandom_range(0, 19) == 0);
         a_real = 16'($urandom_range(0, 65535));
         a_imag = 16'($urandom_range(0, 65535));
         b_real = 16'($urandom_range(0, 65535));
         b_imag = 16'($urandom_range(0, 65535));
         twiddle_real = TW'(int'($urandom_range(0, 512)) - 256);
         twiddle_imag = TW'(int'($urandom_range(0, 512)) - 256);
         if (clk_en && i_valid) nsent++;
         step();
      end
      clk_en = 1'b1;
      clr_ovf = 1'b0;
      idle(6);
      check("drained", longint'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
